// File: rtl/stream_mux_pkg.sv
// Shared types and index helpers for the N-channel round-robin stream mux.
package stream_mux_pkg;

  typedef enum logic {
    MODE_RR    = 1'b0,
    MODE_FIXED = 1'b1
  } mode_e;

  // Wrap-around increment that works for any channel count, not only powers of two.
  function automatic int next_idx(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/stream_mux_rr_if.sv
// Handshake bundle between producers/consumer and the stream mux.
interface stream_mux_rr_if #(
  parameter int K = 8,
  parameter int N = 4
);
  localparam int SW = $clog2(N);

  logic [N*K-1:0] IN_DATA;
  logic [N-1:0]   IN_VALID;
  logic [N-1:0]   IN_READY;
  logic           MODE;
  logic [SW-1:0]  SEL;
  logic [K-1:0]   O;
  logic [SW-1:0]  O_CH;
  logic           O_VALID;
  logic           O_READY;

  modport master (
    output IN_DATA, IN_VALID, MODE, SEL, O_READY,
    input  IN_READY, O, O_CH, O_VALID
  );

  modport slave (
    input  IN_DATA, IN_VALID, MODE, SEL, O_READY,
    output IN_READY, O, O_CH, O_VALID
  );
endinterface

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after PTR, wrapping modulo N.
module rr_arbiter #(
  parameter int N = 4,
  localparam int SW = $clog2(N)
) (
  input  logic [N-1:0]  REQ,
  input  logic [SW-1:0] PTR,
  input  logic          EN,
  output logic [N-1:0]  GNT,
  output logic [SW-1:0] GNT_IDX
);

  int   idx;
  logic found;

  // Offsets are scanned in priority order; the inner loop keeps every select constant.
  always_comb begin
    GNT     = '0;
    GNT_IDX = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(PTR) + k;
      if (idx >= N) idx = idx - N;
      for (int i = 0; i < N; i++) begin
        if (EN && !found && (i == idx) && REQ[i]) begin
          GNT[i]  = 1'b1;
          GNT_IDX = SW'(i);
          found   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N:1 stream mux with round-robin or fixed selection into a single registered output stage.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int K = 8,
  parameter int N = 4
) (
  input  logic            CLK,
  input  logic            RST_N,
  stream_mux_rr_if.slave  bus
);

  localparam int SW = $clog2(N);

  mode_e         mode;
  logic [N-1:0]  rr_gnt;
  logic [N-1:0]  fix_gnt;
  logic [N-1:0]  gnt;
  logic [SW-1:0] rr_idx;
  logic [SW-1:0] gnt_idx;
  logic          slot;
  logic          xfer;

  logic [K-1:0]  o_q, o_d;
  logic [SW-1:0] o_ch_q, o_ch_d;
  logic          o_vld_q, o_vld_d;
  logic [SW-1:0] ptr_q, ptr_d;

  assign mode = mode_e'(bus.MODE);

  rr_arbiter #(.N(N)) u_arb (
    .REQ     (bus.IN_VALID),
    .PTR     (ptr_q),
    .EN      (mode == MODE_RR),
    .GNT     (rr_gnt),
    .GNT_IDX (rr_idx)
  );

  // An out-of-range SEL matches no channel, so it simply yields no grant.
  always_comb begin
    fix_gnt = '0;
    for (int i = 0; i < N; i++) begin
      if ((int'(bus.SEL) == i) && bus.IN_VALID[i]) fix_gnt[i] = 1'b1;
    end
  end

  assign gnt          = (mode == MODE_FIXED) ? fix_gnt : rr_gnt;
  assign gnt_idx      = (mode == MODE_FIXED) ? bus.SEL : rr_idx;
  assign slot         = !o_vld_q || bus.O_READY;
  assign bus.IN_READY = (slot && RST_N) ? gnt : '0;
  assign xfer         = |(bus.IN_VALID & bus.IN_READY);

  // Refill and consume may coincide, which sustains one word per cycle.
  always_comb begin
    o_d     = o_q;
    o_ch_d  = o_ch_q;
    o_vld_d = o_vld_q;
    ptr_d   = ptr_q;
    if (xfer) begin
      for (int i = 0; i < N; i++) begin
        if (gnt[i]) o_d = bus.IN_DATA[i*K +: K];
      end
      o_ch_d  = gnt_idx;
      o_vld_d = 1'b1;
      if (mode == MODE_RR) ptr_d = SW'(next_idx(int'(gnt_idx), N));
    end else if (o_vld_q && bus.O_READY) begin
      o_vld_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      o_q     <= '0;
      o_ch_q  <= '0;
      o_vld_q <= 1'b0;
      ptr_q   <= '0;
    end else begin
      o_q     <= o_d;
      o_ch_q  <= o_ch_d;
      o_vld_q <= o_vld_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.O       = o_q;
  assign bus.O_CH    = o_ch_q;
  assign bus.O_VALID = o_vld_q;

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- N-channel, W-bit successor to the byte 2:1 mux.
- Each input channel has a valid/ready handshake. The block selects one channel per cycle and registers it into a single output stage with its own valid/ready handshake.
- Two selection modes: round-robin arbitration, or fixed selection by an external SEL input (the legacy behaviour).
- Sits between producers (register file read ports, ALU result sources) and a shared consumer such as a writeback or bus port.

Parameters:
- K, 8, data width per channel in bits (K >= 1).
- N, 4, number of input channels (N >= 2; need not be a power of two).
- SW, $clog2(N), width of the channel index (derived; not overridden).

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- IN_DATA  input  N*K  packed channel data; channel i occupies bits [i*K +: K].
- IN_VALID  input  N  per-channel valid.
- IN_READY  output  N  per-channel ready (combinational).
- MODE  input  1  0 = round-robin, 1 = fixed select.
- SEL  input  SW  selected channel when MODE=1.
- O  output  K  registered output data.
- O_CH  output  SW  index of the channel that supplied O.
- O_VALID  output  1  output register holds data.
- O_READY  input  1  consumer accepts O this cycle.

Behaviour:
- Reset (RST_N=0, asynchronous):
  - O=0, O_CH=0, O_VALID=0, round-robin pointer PTR=0.
  - IN_READY=0 while reset is asserted.
- Output stage availability: SLOT = !O_VALID || O_READY.
- Grant (combinational, at most one bit set):
  - MODE=0: the first i with IN_VALID[i]=1, searching PTR, PTR+1, … N-1, 0, … PTR-1 (modulo N).
  - MODE=1: grant channel SEL if IN_VALID[SEL]=1. If SEL >= N, no grant.
- IN_READY[i] = GNT[i] && SLOT. No ready is asserted to a non-granted channel.
- Transfer on input i when IN_VALID[i] && IN_READY[i]. At the next edge: O <= channel i data, O_CH <= i, O_VALID <= 1.
- Consume without a new transfer (O_VALID && O_READY, no input transfer): O_VALID <= 0. O and O_CH hold their last values.
- Simultaneous consume and transfer: the register is refilled in the same edge, giving 1 transfer per cycle sustained.
- Stall (O_VALID && !O_READY): O, O_CH and O_VALID hold; IN_READY is all zero.
- Latency: an input transfer in cycle t appears on O/O_VALID in cycle t+1.
- PTR update:
  - Only on an input transfer while MODE=0: PTR <= (granted index + 1), wrapping N-1 -> 0. No update otherwise.
  - MODE=1 transfers leave PTR unchanged.
- Switching MODE takes effect on the grant in the same cycle. Data already held in the output register is unaffected.
- Input-side rule: a channel keeps its data stable while IN_VALID=1 and IN_READY=0. The block tolerates violations but only the transferred value is defined.
- Reset mid-operation: any held output word is discarded; O_VALID drops immediately (asynchronously).
- The output never bypasses combinationally; O is always a register output.

Decomposition:
- Shared package stream_mux_pkg:
  - typedef enum {MODE_RR=1'b0, MODE_FIXED=1'b1}.
  - A function computing the wrap-around next index for a non-power-of-two N.
- One sub-module, rr_arbiter:
  - Parameter N.
  - Inputs REQ[N], PTR[SW], EN.
  - Outputs GNT[N] (one-hot or zero) and GNT_IDX[SW].
  - Purely combinational.
- The top level owns PTR, the output register and the handshake logic.

Test Plan:
- Reset/idle: assert RST_N=0 mid-cycle with O_VALID=1 -> O_VALID=0, O=0, O_CH=0 immediately. Release with no IN_VALID -> O_VALID stays 0 and IN_READY=4'b0000.
- Round-robin fairness: N=4, K=8, MODE=0, IN_VALID=4'b1111, data 8'hA0+i, O_READY=1 -> O sequence A0,A1,A2,A3,A0. O_CH sequence 0,1,2,3,0. One word per cycle after the 1-cycle latency.
- Sparse requests and wrap: IN_VALID=4'b1001, PTR=0 -> grants ch0 then ch3 then ch0. IN_READY pattern is 0001, 1000, 0001.
- Backpressure: hold O_READY=0 after the first word -> O stays 8'hA0, O_VALID=1, IN_READY=0000. Raise O_READY -> the next word loads the same cycle with no bubble.
- Fixed mode: MODE=1, SEL=2, IN_VALID=4'b1111 -> only ch2 is transferred (O=A2 each cycle) and PTR is unchanged. SEL=3 with IN_VALID[3]=0 -> no transfer and O_VALID falls after the consume.
- Non-power-of-two: N=3, all channels valid -> O_CH cycles 0,1,2,0, and PTR never reaches 3.
